// File: rtl/chip8_draw_sequencer.sv
// Multi-cycle DXYN sprite draw / 00E0 clear engine for the CHIP-8 core.
// Owns the single framebuffer port and shares it with scanout via a 1-bit round-robin.
module chip8_draw_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear,
  input  logic [5:0]  x,
  input  logic [4:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic        mem_rd,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        fb_rd,
  output logic        fb_wr,
  output logic [4:0]  fb_addr,
  output logic [63:0] fb_wdata,
  input  logic [63:0] fb_rdata,
  input  logic        scan_req,
  input  logic [4:0]  scan_addr,
  output logic        scan_gnt
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, CLEAR, DONE} state_t;

  typedef struct packed {
    logic [5:0]  x;
    logic [4:0]  y;
    logic [3:0]  n;
    logic [11:0] base;
  } draw_req_t;

  state_t       st, st_nxt;
  draw_req_t    req_q;
  logic [3:0]   row_q;
  logic [4:0]   clr_row_q;
  logic [63:0]  wdata_q;
  logic         ptr_scan_q;
  logic         seq_req, seq_gnt;
  logic [4:0]   draw_row;
  logic         last_row;
  logic [127:0] line_dbl;
  logic [63:0]  line;

  assign draw_row = req_q.y + {1'b0, row_q};
  assign last_row = (row_q + 4'd1) == req_q.n;
  // Shifting a doubled copy gives a 64-bit rotate: columns past 63 wrap to column 0.
  assign line_dbl = {mem_rdata, 56'b0, mem_rdata, 56'b0} >> req_q.x;
  assign line     = line_dbl[63:0];

  // Contested cycles go to whoever the pointer favours; uncontested requester always wins.
  always_comb begin
    seq_req  = (st == READ) || (st == WRITE) || (st == CLEAR);
    seq_gnt  = seq_req  && !(scan_req && ptr_scan_q);
    scan_gnt = scan_req && !(seq_req && !ptr_scan_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: begin
        if (clear)      st_nxt = CLEAR;
        else if (start) st_nxt = (n == 4'd0) ? DONE : READ;
      end
      READ:  if (seq_gnt) st_nxt = MERGE;
      MERGE: st_nxt = WRITE;
      WRITE: if (seq_gnt) st_nxt = last_row ? DONE : READ;
      CLEAR: if (seq_gnt && clr_row_q == 5'd31) st_nxt = DONE;
      DONE:  st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      row_q      <= '0;
      clr_row_q  <= '0;
      wdata_q    <= '0;
      collision  <= 1'b0;
      ptr_scan_q <= 1'b1;
    end else begin
      if (seq_req && scan_req) ptr_scan_q <= ~ptr_scan_q;
      case (st)
        IDLE: begin
          if (clear) begin
            collision <= 1'b0;
            clr_row_q <= '0;
          end else if (start) begin
            req_q     <= {x, y, n, base_addr};
            row_q     <= '0;
            collision <= 1'b0;
          end
        end
        MERGE: begin
          wdata_q   <= fb_rdata ^ line;
          collision <= collision | (|(fb_rdata & line));
        end
        WRITE: if (seq_gnt) row_q <= row_q + 4'd1;
        CLEAR: if (seq_gnt) clr_row_q <= clr_row_q + 5'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (st != IDLE);
    done     = (st == DONE);
    mem_rd   = (st == READ);
    mem_addr = mem_rd ? (req_q.base + {8'b0, row_q}) : 12'd0;
    fb_rd    = scan_gnt || (seq_gnt && st == READ);
    fb_wr    = seq_gnt && (st == WRITE || st == CLEAR);
    fb_wdata = (seq_gnt && st == WRITE) ? wdata_q : 64'd0;
    fb_addr  = 5'd0;
    if (scan_gnt)     fb_addr = scan_addr;
    else if (seq_gnt) fb_addr = (st == CLEAR) ? clr_row_q : draw_row;
  end

endmodule

// File: doc/chip8_draw_sequencer.md
# chip8_draw_sequencer

Multi-cycle sprite-draw and screen-clear controller for the CHIP-8 core. It replaces the single-cycle combinational DXYN/00E0 path. On a CPU request it fetches sprite bytes from main memory one row at a time and read-modify-writes the 64x32 framebuffer. It also arbitrates the framebuffer's single port between itself and the display scanout reader.

## Interface
- No parameters; geometry fixed at 64x32 framebuffer, 4 KiB memory, max 15 sprite rows.
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  draw request, sampled only in IDLE
- clear  in  1  clear-screen request, sampled only in IDLE
- x  in  6  sprite column
- y  in  5  sprite row
- n  in  4  sprite height in rows (0..15)
- base_addr  in  12  address register I at request time
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- collision  out  1  VF result; valid from done, held until next accepted request
- mem_rd  out  1  memory read strobe
- mem_addr  out  12  memory read address
- mem_rdata  in  8  read data, valid the cycle after mem_rd
- fb_rd  out  1  framebuffer read strobe (either requester)
- fb_wr  out  1  framebuffer write strobe (sequencer only)
- fb_addr  out  5  framebuffer row address
- fb_wdata  out  64  write row; bit 63 = column 0
- fb_rdata  in  64  read row, valid the cycle after fb_rd
- scan_req  in  1  scanout requests a row read this cycle
- scan_addr  in  5  scanout row
- scan_gnt  out  1  combinational grant; scanout data on fb_rdata next cycle

## Operation
- States: IDLE, READ, MERGE, WRITE, CLEAR, DONE.
- Request acceptance:
  - IDLE with clear=1 goes to CLEAR. Clear has priority over a simultaneous start, which is dropped.
  - IDLE with start=1 latches x, y, n, base_addr, sets row counter r=0, clears collision, and goes to READ (or to DONE if n=0).
  - start or clear while busy is ignored and not queued.
- READ (needs fb grant):
  - Asserts mem_rd with mem_addr=(base+r) mod 4096.
  - Asserts fb_rd with fb_addr=(y+r) mod 32.
  - If the grant is lost, it stays in READ and reissues both reads next cycle.
- MERGE:
  - Captures mem_rdata and fb_rdata.
  - Builds line = rotate_right({byte,56'b0}, x). Horizontal wrap: columns 57..63 spill into columns 0..6.
  - Registers wdata = fb_row ^ line.
  - Sets collision |= ((fb_row & line) != 0).
- WRITE (needs fb grant):
  - Asserts fb_wr with the registered wdata at row (y+r) mod 32.
  - If the grant is lost, it holds wdata and retries.
  - On a granted write: r++. If r==n go to DONE, else go to READ.
- CLEAR (needs grant per row):
  - Writes 64'b0 to rows 0..31 in order, advancing only on granted cycles.
  - After row 31 goes to DONE; collision is forced to 0.
- DONE: done=1 for one cycle, then IDLE.
- Arbitration of the fb port, when both the sequencer (READ/WRITE/CLEAR) and scan_req want it:
  - A 1-bit round-robin pointer picks the winner; after each contested cycle the pointer favours the loser.
  - Uncontested requester always wins.
  - Pointer resets to favour scanout.
- fb port muxing:
  - fb_addr/fb_rd follow the winner.
  - fb_wr is never asserted on a scanout-granted cycle.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, collision=0.
  - mem_rd=0, fb_rd=0, fb_wr=0, scan_gnt=0.
  - mem_addr=0, fb_addr=0, fb_wdata=0, pointer=scan.
- Uncontested draw with start sampled at edge 0:
  - Each row takes 3 cycles: READ, MERGE, WRITE.
  - done is high in cycle 3n+1; n=0 gives done in cycle 1 with no memory or fb accesses.
- Uncontested clear: CLEAR in cycles 1..32, done in cycle 33.
- Each lost arbitration adds exactly one cycle.
- Reset asserted mid-operation: immediate return to IDLE with all strobes low. A partially drawn sprite stays partially drawn; no further writes occur.
- scan_gnt is combinational from scan_req and sequencer state. With no sequencer demand, scan_gnt=scan_req.

## Test plan
- Draw n=5 at base 0x050 (font "0": F0 90 90 90 F0), x=0, y=0, on a cleared fb.
  - Rows 0..4 become F0000000_00000000, 90000000_00000000, …
  - collision=0; done in cycle 16.
- Repeat the identical draw.
  - All five rows return to 0; collision=1.
- x=60, y=30, n=3, bytes FF FF FF.
  - Rows 30, 31, 0 each equal F000000000000000 | 000000000000000F.
  - mem_addr wraps correctly when base=0xFFE (reads 0xFFE, 0xFFF, 0x000).
- scan_req held high continuously during an n=2 draw.
  - Grants alternate and the draw completes.
  - done at cycle 7 + number of lost arbitrations (one lost per contested READ/WRITE, since the pointer starts at scan).
  - Scanout is never starved more than 1 consecutive cycle.
- clear and start asserted together in IDLE.
  - Clear executes: 32 zero writes, done at cycle 33, collision=0.
  - The draw is not performed; start pulses during busy are ignored.
- rst_n pulsed low during WRITE of row 2 of an n=4 draw.
  - Rows 0..1 retain their new data; no further fb_wr.
  - Outputs are at reset values; the next start runs normally.
